spi_bus_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares one SPI byte engine (CPOL=1/CPHA=1, 8-bit transfers) between N_REQ requesters.
- Owns one active-low chip select per requester and locks the grant for a whole multi-byte packet.
- Feeds tx bytes to the engine, returns rx bytes to the owner, and aborts a stalled engine with a watchdog.

---
 rtl/spi_bus_arbiter_if.sv | 32 +++
 rtl/spi_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and byte-engine-side signals of the SPI bus arbiter.
// The arbiter uses the master modport; whoever drives requests and the engine uses the slave modport.
interface spi_bus_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]   req_i;
    logic [N_REQ-1:0]   gnt_o;
    logic [N_REQ-1:0]   tx_valid_i;
    logic [8*N_REQ-1:0] tx_data_i;
    logic [N_REQ-1:0]   tx_last_i;
    logic [N_REQ-1:0]   tx_ready_o;
    logic [N_REQ-1:0]   rx_valid_o;
    logic [7:0]         rx_data_o;
    logic [N_REQ-1:0]   err_o;
    logic [N_REQ-1:0]   cs_n_o;
    logic               eng_start_o;
    logic [7:0]         eng_tx_o;
    logic               eng_done_i;
    logic [7:0]         eng_rx_i;

    modport master (
        input  req_i, tx_valid_i, tx_data_i, tx_last_i, eng_done_i, eng_rx_i,
        output gnt_o, tx_ready_o, rx_valid_o, rx_data_o, err_o, cs_n_o,
               eng_start_o, eng_tx_o
    );

    modport slave (
        output req_i, tx_valid_i, tx_data_i, tx_last_i, eng_done_i, eng_rx_i,
        input  gnt_o, tx_ready_o, rx_valid_o, rx_data_o, err_o, cs_n_o,
               eng_start_o, eng_tx_o
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of a shared SPI byte engine: locks one requester per packet,
// sequences chip select setup/hold and aborts a stalled engine with a watchdog.
module spi_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    spi_bus_arbiter_if.master bus
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, HOLD} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] rr_reg;
    logic [IDX_W-1:0] owner_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WD_W-1:0]  wd_reg;
    logic             last_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [N_REQ-1:0] cs_n_reg;
    logic [N_REQ-1:0] tx_ready_reg;
    logic [N_REQ-1:0] rx_valid_reg;
    logic [N_REQ-1:0] err_reg;
    logic [7:0]       rx_data_reg;
    logic             eng_start_reg;
    logic [7:0]       eng_tx_reg;

    logic [IDX_W-1:0] pick;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] owner_oh;
    logic             tx_valid_sel;
    logic             tx_last_sel;
    logic [7:0]       tx_data_sel;

    // Walk offsets downward so the smallest offset from the rr pointer wins.
    always_comb begin
        int idx;
        pick = '0;
        idx  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_reg) + i) % N_REQ;
            if (bus.req_i[idx]) pick = IDX_W'(idx);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign pick_oh[gi]  = (pick == IDX_W'(gi));
            assign owner_oh[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    assign tx_valid_sel = bus.tx_valid_i[owner_reg];
    assign tx_last_sel  = bus.tx_last_i[owner_reg];
    assign tx_data_sel  = bus.tx_data_i[{owner_reg, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_reg        <= '0;
            owner_reg     <= '0;
            cnt_reg       <= '0;
            wd_reg        <= '0;
            last_reg      <= 1'b0;
            gnt_reg       <= '0;
            cs_n_reg      <= '1;
            tx_ready_reg  <= '0;
            rx_valid_reg  <= '0;
            err_reg       <= '0;
            rx_data_reg   <= '0;
            eng_start_reg <= 1'b0;
            eng_tx_reg    <= '0;
        end else begin
            rx_valid_reg  <= '0;
            err_reg       <= '0;
            eng_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|bus.req_i) begin
                        owner_reg <= pick;
                        gnt_reg   <= pick_oh;
                        cs_n_reg  <= ~pick_oh;
                        cnt_reg   <= '0;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == CNT_W'(CS_SETUP - 1)) begin
                        tx_ready_reg <= owner_oh;
                        state_reg    <= ISSUE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ISSUE: begin
                    if (tx_valid_sel) begin
                        eng_tx_reg    <= tx_data_sel;
                        last_reg      <= tx_last_sel;
                        eng_start_reg <= 1'b1;
                        tx_ready_reg  <= '0;
                        wd_reg        <= '0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.eng_done_i) begin
                        rx_valid_reg <= owner_oh;
                        rx_data_reg  <= bus.eng_rx_i;
                        if (last_reg) begin
                            cnt_reg   <= '0;
                            state_reg <= HOLD;
                        end else begin
                            tx_ready_reg <= owner_oh;
                            state_reg    <= ISSUE;
                        end
                    end else if (wd_reg == WD_W'(TIMEOUT)) begin
                        // Engine stalled: drop the rest of the packet.
                        err_reg   <= owner_oh;
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_reg == CNT_W'(CS_HOLD - 1)) begin
                        gnt_reg   <= '0;
                        cs_n_reg  <= '1;
                        rr_reg    <= (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o       = gnt_reg;
    assign bus.cs_n_o      = cs_n_reg;
    assign bus.tx_ready_o  = tx_ready_reg;
    assign bus.rx_valid_o  = rx_valid_reg;
    assign bus.rx_data_o   = rx_data_reg;
    assign bus.err_o       = err_reg;
    assign bus.eng_start_o = eng_start_reg;
    assign bus.eng_tx_o    = eng_tx_reg;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: a packet-level timeline model checked every cycle,
// an echoing byte engine, and directed scenarios with literal expectations.
module tb_spi_bus_arbiter;
    localparam int N        = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int TIMEOUT  = 1023;
    localparam int ENG_LAT  = 40;
    localparam int WAIT_MAX = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_bus_arbiter_if #(.N_REQ(N)) bus ();

    spi_bus_arbiter #(
        .N_REQ(N), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event within %0d cycles, required the event (t=%0t)", name, WAIT_MAX, $time);
    endtask

    function automatic logic [N-1:0] oh(input int w);
        logic [N-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- packet-level timeline model ----------------
    logic [N-1:0] m_gnt, m_ready, m_rxv, m_err, m_csn;
    logic         m_start;
    logic [7:0]   m_etx, m_rxd;
    int           rr_m;

    task automatic m_reset();
        m_gnt = '0; m_ready = '0; m_rxv = '0; m_err = '0; m_csn = '1;
        m_start = 1'b0; m_etx = '0; m_rxd = '0; rr_m = 0;
    endtask

    // One clock edge as the model sees it: pulses last exactly one cycle.
    task automatic m_tick(output bit aborted);
        @(posedge clk);
        m_rxv = '0; m_err = '0; m_start = 1'b0;
        aborted = rst;
        if (rst) m_reset();
    endtask

    task automatic model_packet(input int w);
        bit ab;
        bit last;
        int k;
        repeat (CS_SETUP) begin m_tick(ab); if (ab) return; end
        m_ready = oh(w);
        forever begin
            do begin m_tick(ab); if (ab) return; end while (bus.tx_valid_i[w] !== 1'b1);
            m_ready = '0;
            m_start = 1'b1;
            m_etx   = bus.tx_data_i[8*w +: 8];
            last    = bus.tx_last_i[w];
            k = 0;
            forever begin
                m_tick(ab); if (ab) return;
                k++;
                if (bus.eng_done_i === 1'b1) begin
                    m_rxv = oh(w);
                    m_rxd = bus.eng_rx_i;
                    break;
                end
                if (k == TIMEOUT + 1) begin
                    m_err = oh(w);
                    last  = 1'b1;
                    break;
                end
            end
            if (last) break;
            m_ready = oh(w);
        end
        repeat (CS_HOLD) begin m_tick(ab); if (ab) return; end
        m_gnt = '0;
        m_csn = '1;
        rr_m  = (w + 1) % N;
    endtask

    initial begin : model
        bit ab;
        int w;
        m_reset();
        forever begin
            m_tick(ab);
            if (ab || bus.req_i == '0) continue;
            w = -1;
            for (int i = 0; i < N; i++)
                if (w < 0 && bus.req_i[(rr_m + i) % N]) w = (rr_m + i) % N;
            m_gnt = oh(w);
            m_csn = ~oh(w);
            model_packet(w);
        end
    end

    // ---------------- compare + event monitor ----------------
    int          cyc = 0, n_start = 0, start_cyc = 0, err_cyc = 0, done_cyc = 0, rise_cyc = 0;
    int          idle_run = 0;
    logic [N-1:0] err_val = '0;
    logic [7:0]  rx_log[$];
    int          gnt_log[$];
    int          gap_log[$];

    initial begin : compare
        logic [N-1:0] prev_gnt, prev_csn;
        logic [N-1:0] e_gnt, e_ready, e_rxv, e_err, e_csn;
        logic         e_start;
        logic [7:0]   e_etx, e_rxd;
        prev_gnt = '0;
        prev_csn = '1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                e_gnt = '0; e_ready = '0; e_rxv = '0; e_err = '0; e_csn = '1;
                e_start = 1'b0; e_etx = '0; e_rxd = '0;
            end else begin
                e_gnt = m_gnt; e_ready = m_ready; e_rxv = m_rxv; e_err = m_err; e_csn = m_csn;
                e_start = m_start; e_etx = m_etx; e_rxd = m_rxd;
            end
            chk("gnt",       32'(bus.gnt_o),       32'(e_gnt));
            chk("cs_n",      32'(bus.cs_n_o),      32'(e_csn));
            chk("tx_ready",  32'(bus.tx_ready_o),  32'(e_ready));
            chk("rx_valid",  32'(bus.rx_valid_o),  32'(e_rxv));
            chk("rx_data",   32'(bus.rx_data_o),   32'(e_rxd));
            chk("err",       32'(bus.err_o),       32'(e_err));
            chk("eng_start", 32'(bus.eng_start_o), 32'(e_start));
            chk("eng_tx",    32'(bus.eng_tx_o),    32'(e_etx));

            if (bus.eng_start_o === 1'b1) begin n_start++; start_cyc = cyc; end
            if (bus.eng_done_i === 1'b1) done_cyc = cyc;
            if (bus.rx_valid_o != '0) begin
                rx_log.push_back(bus.rx_data_o);
                $display("[%0t] rx    req=%0d data=%02h", $time, oh_idx(bus.rx_valid_o), bus.rx_data_o);
            end
            if (bus.err_o != '0) begin
                err_cyc = cyc;
                err_val = bus.err_o;
                $display("[%0t] abort req=%0d", $time, oh_idx(bus.err_o));
            end
            if (prev_gnt == '0 && bus.gnt_o != '0) begin
                gnt_log.push_back(oh_idx(bus.gnt_o));
                gap_log.push_back(idle_run);
                $display("[%0t] grant req=%0d", $time, oh_idx(bus.gnt_o));
            end
            if (prev_csn != '1 && bus.cs_n_o == '1) rise_cyc = cyc;
            idle_run = (bus.cs_n_o == '1) ? idle_run + 1 : 0;
            prev_gnt = bus.gnt_o;
            prev_csn = bus.cs_n_o;
        end
    end

    // ---------------- byte engine: echoes the inverted byte ----------------
    bit eng_echo = 1'b1;

    initial begin : engine
        logic [7:0] b;
        bus.eng_done_i = 1'b0;
        bus.eng_rx_i   = '0;
        forever begin
            @(negedge clk);
            if (bus.eng_start_o === 1'b1 && eng_echo) begin
                b = bus.eng_tx_o;
                repeat (ENG_LAT) @(posedge clk);
                #1;
                bus.eng_done_i = 1'b1;
                bus.eng_rx_i   = ~b;
                @(posedge clk);
                #1;
                bus.eng_done_i = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_gnt(input int r);
        for (int c = 0; c < WAIT_MAX; c++) begin
            @(posedge clk); #1;
            if (bus.gnt_o[r] === 1'b1) return;
        end
        bound_fail("wait_gnt");
    endtask

    task automatic wait_gnt_any(output int r);
        r = 0;
        for (int c = 0; c < WAIT_MAX; c++) begin
            @(posedge clk); #1;
            if (bus.gnt_o != '0) begin r = oh_idx(bus.gnt_o); return; end
        end
        bound_fail("wait_gnt_any");
    endtask

    task automatic wait_idle();
        for (int c = 0; c < WAIT_MAX; c++) begin
            @(posedge clk); #1;
            if (bus.gnt_o == '0) begin @(negedge clk); #1; return; end
        end
        bound_fail("wait_idle");
    endtask

    task automatic send_byte(input int r, input logic [7:0] d, input bit last);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < WAIT_MAX && !ok; c++) begin
            @(posedge clk); #1;
            ok = (bus.tx_ready_o[r] === 1'b1);
        end
        if (!ok) begin bound_fail("wait_ready"); return; end
        bus.tx_valid_i[r]       = 1'b1;
        bus.tx_data_i[8*r +: 8] = d;
        bus.tx_last_i[r]        = last;
        @(posedge clk); #1;
        bus.tx_valid_i[r] = 1'b0;
        bus.tx_last_i[r]  = 1'b0;
    endtask

    initial begin : timeout_guard
        #2_000_000;
        $display("FAIL sim_time: got end of time budget, required $finish before it");
        $fatal(1, "simulation time budget exhausted");
    end

    // ---------------- directed scenarios ----------------
    int gnt_exp[14];

    initial begin : stimulus
        int r, s0, r0;
        logic [7:0] exp_rx[3];
        bus.req_i      = '0;
        bus.tx_valid_i = '0;
        bus.tx_data_i  = '0;
        bus.tx_last_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All four requesting, single-byte packets: rotation 0,1,2,3,0.
        bus.req_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt_any(r);
            if (g == 4) bus.req_i = '0;
            send_byte(r, 8'(8'h10 + g), 1'b1);
            wait_idle();
        end
        for (int g = 1; g < 5 && g < gap_log.size(); g++)
            chk("gap_between_grants", 32'(gap_log[g] >= 1), 32'd1);

        // Requester 1, three-byte packet.
        bus.req_i = 4'b0010;
        wait_gnt(1);
        bus.req_i = '0;
        chk("pkt1_cs_n", 32'(bus.cs_n_o), 32'h0000_000D);
        s0 = n_start;
        r0 = rx_log.size();
        send_byte(1, 8'hA5, 1'b0);
        send_byte(1, 8'h3C, 1'b0);
        send_byte(1, 8'hFF, 1'b1);
        wait_idle();
        exp_rx = '{8'h5A, 8'hC3, 8'h00};
        chk("pkt1_starts", 32'(n_start - s0), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("pkt1_rx", (r0 + i < rx_log.size()) ? 32'(rx_log[r0 + i]) : 32'hDEAD, 32'(exp_rx[i]));
        chk("pkt1_cs_release", 32'(rise_cyc - done_cyc), 32'(CS_HOLD + 1));

        // Grant lock: 2 drops its request, 0 raises one mid-packet.
        bus.req_i = 4'b0100;
        wait_gnt(2);
        send_byte(2, 8'h81, 1'b0);
        bus.req_i = 4'b0001;
        send_byte(2, 8'h82, 1'b0);
        chk("lock_gnt", 32'(bus.gnt_o), 32'h0000_0004);
        send_byte(2, 8'h83, 1'b1);
        wait_gnt(0);
        bus.req_i = '0;
        send_byte(0, 8'h44, 1'b1);
        wait_idle();

        // Silent engine on requester 3; requester 0 waits behind it.
        eng_echo  = 1'b0;
        bus.req_i = 4'b1000;
        wait_gnt(3);
        bus.req_i = 4'b0001;
        r0 = rx_log.size();
        send_byte(3, 8'h77, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < WAIT_MAX && !seen; c++) begin
                @(posedge clk); #1;
                seen = (bus.err_o != '0);
            end
            if (!seen) bound_fail("wait_err");
        end
        eng_echo = 1'b1;
        @(negedge clk); #1;
        chk("abort_timing", 32'(err_cyc - start_cyc), 32'(TIMEOUT + 1));
        chk("abort_owner", 32'(err_val), 32'h0000_0008);
        chk("abort_no_rx", 32'(rx_log.size() - r0), 32'd0);
        wait_gnt(0);
        bus.req_i = '0;
        send_byte(0, 8'h55, 1'b1);
        wait_idle();

        // Requester 1 holds back tx_valid for 500 cycles.
        bus.req_i = 4'b0010;
        wait_gnt(1);
        bus.req_i = '0;
        repeat (CS_SETUP + 2) @(posedge clk);
        s0 = n_start;
        repeat (500) @(posedge clk);
        #1;
        chk("stall_no_start", 32'(n_start - s0), 32'd0);
        chk("stall_cs_n", 32'(bus.cs_n_o), 32'h0000_000D);
        chk("stall_ready", 32'(bus.tx_ready_o), 32'h0000_0002);
        send_byte(1, 8'h66, 1'b1);
        wait_idle();
        chk("stall_rx", (rx_log.size() > 0) ? 32'(rx_log[rx_log.size() - 1]) : 32'hDEAD, 32'h0000_0099);

        // Reset in the middle of byte 2 of a packet on requester 2.
        bus.req_i = 4'b0100;
        wait_gnt(2);
        bus.req_i = '0;
        send_byte(2, 8'h11, 1'b0);
        send_byte(2, 8'h22, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_cs_n", 32'(bus.cs_n_o), 32'h0000_000F);
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (ENG_LAT + 20) @(posedge clk);
        #1;
        bus.req_i = 4'b1010;
        wait_gnt_any(r);
        bus.req_i = '0;
        chk("rr_after_rst", 32'(r), 32'd1);
        send_byte(r, 8'h01, 1'b1);
        wait_idle();
        bus.req_i = 4'b0100;
        wait_gnt(2);
        bus.req_i = '0;
        send_byte(2, 8'h02, 1'b1);
        wait_idle();

        repeat (5) @(posedge clk);
        gnt_exp = '{0, 1, 2, 3, 0, 1, 2, 0, 3, 0, 1, 2, 1, 2};
        chk("grant_count", 32'(gnt_log.size()), 32'd14);
        for (int i = 0; i < 14; i++)
            chk("grant_order", (i < gnt_log.size()) ? 32'(gnt_log[i]) : 32'hDEAD, 32'(gnt_exp[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
